// File: rtl/active_list_retire_if.sv
// Rename <-> active list handshake bundle: push, writeback completion, retire/release, flush and occupancy.
interface active_list_retire_if #(
  parameter int DEPTH  = 16,
  parameter int PHYS_W = 6,
  parameter int ARCH_W = 5
);
  localparam int TAG_W = $clog2(DEPTH);

  logic              alloc_valid;
  logic              alloc_ready;
  logic [ARCH_W-1:0] alloc_arch_rd;
  logic [PHYS_W-1:0] alloc_new_phys;
  logic [PHYS_W-1:0] alloc_old_phys;
  logic [TAG_W-1:0]  alloc_tag;
  logic              done_valid;
  logic [TAG_W-1:0]  done_tag;
  logic              release_valid;
  logic              release_ready;
  logic [PHYS_W-1:0] release_phys;
  logic [ARCH_W-1:0] commit_arch_rd;
  logic [PHYS_W-1:0] commit_phys;
  logic              flush;
  logic [TAG_W:0]    count;
  logic              empty;

  modport slave (
    input  alloc_valid, alloc_arch_rd, alloc_new_phys, alloc_old_phys,
    input  done_valid, done_tag, release_ready, flush,
    output alloc_ready, alloc_tag, release_valid, release_phys,
    output commit_arch_rd, commit_phys, count, empty
  );

  modport master (
    output alloc_valid, alloc_arch_rd, alloc_new_phys, alloc_old_phys,
    output done_valid, done_tag, release_ready, flush,
    input  alloc_ready, alloc_tag, release_valid, release_phys,
    input  commit_arch_rd, commit_phys, count, empty
  );
endinterface

// File: rtl/active_list_retire.sv
// In-order active list: push at tail, complete by tag, retire from head 1 cycle after done; release_ready=0 holds head stable.
// No bypass when full; flush is level, highest priority. RETIRE_STATS_EN adds retire_cnt/stall_cnt counters.
module active_list_retire #(
  parameter int  DEPTH  = 16,
  parameter int  PHYS_W = 6,
  parameter int  ARCH_W = 5,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  active_list_retire_if.slave bus
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]         retire_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam logic [TAG_W:0] LP_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] LP_ONE  = (TAG_W+1)'(1);

  logic [TAG_W:0]    r_head;
  logic [TAG_W:0]    r_tail;
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [ARCH_W-1:0] r_arch [DEPTH];
  logic [PHYS_W-1:0] r_new  [DEPTH];
  logic [PHYS_W-1:0] r_old  [DEPTH];

  logic [TAG_W:0]    w_count;
  logic [TAG_W-1:0]  w_head_idx;
  logic [TAG_W-1:0]  w_tail_idx;
  logic              w_alloc_rdy;
  logic              w_release_vld;
  logic              w_push;
  logic              w_retire;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [DEPTH-1:0]  w_done_nxt;

  assign w_count       = r_tail - r_head;
  assign w_head_idx    = r_head[TAG_W-1:0];
  assign w_tail_idx    = r_tail[TAG_W-1:0];
  assign w_alloc_rdy   = (w_count != LP_FULL);
  assign w_release_vld = r_valid[w_head_idx] & r_done[w_head_idx] & ~bus.flush;
  assign w_push        = bus.alloc_valid & w_alloc_rdy & ~bus.flush;
  assign w_retire      = w_release_vld & bus.release_ready;

  assign bus.alloc_ready   = w_alloc_rdy;
  assign bus.alloc_tag     = w_tail_idx;
  assign bus.release_valid = w_release_vld;
  assign bus.count         = w_count;
  assign bus.empty         = (w_count == '0);

  // Retire data is zeroed whenever no retirement is offered.
  always_comb begin
    bus.release_phys   = '0;
    bus.commit_arch_rd = '0;
    bus.commit_phys    = '0;
    if (w_release_vld) begin
      bus.release_phys   = r_old[w_head_idx];
      bus.commit_arch_rd = r_arch[w_head_idx];
      bus.commit_phys    = r_new[w_head_idx];
    end
  end

  // Completions to non-valid slots are dropped; a push always lands with done cleared.
  always_comb begin
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    if (bus.done_valid && r_valid[bus.done_tag]) begin
      w_done_nxt[bus.done_tag] = 1'b1;
    end
    if (w_retire) begin
      w_valid_nxt[w_head_idx] = 1'b0;
      w_done_nxt[w_head_idx]  = 1'b0;
    end
    if (w_push) begin
      w_valid_nxt[w_tail_idx] = 1'b1;
      w_done_nxt[w_tail_idx]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + LP_ONE;
      end
      if (w_retire) begin
        r_head <= r_head + LP_ONE;
      end
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_arch[w_tail_idx] <= bus.alloc_arch_rd;
      r_new[w_tail_idx]  <= bus.alloc_new_phys;
      r_old[w_tail_idx]  <= bus.alloc_old_phys;
    end
  end

`ifdef RETIRE_STATS_EN
  logic [31:0] r_retire_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_retire && (r_retire_cnt != 32'hFFFF_FFFF)) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      if (bus.alloc_valid && !w_alloc_rdy) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_active_list_retire.sv
// Directed bench for active_list_retire: vector table for single-cycle behaviour plus full, wrap, reset and stats sequences.
module tb_active_list_retire;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  active_list_retire_if #(.DEPTH(16), .PHYS_W(6), .ARCH_W(5)) bus ();

`ifdef RETIRE_STATS_EN
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;
`endif

  active_list_retire #(.DEPTH(16), .PHYS_W(6), .ARCH_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RETIRE_STATS_EN
    ,
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [4:0] rd;
    logic [5:0] np;
    logic [5:0] op;
    logic       dv;
    logic [3:0] dt;
    logic       rr;
    logic       fl;
    logic       ardy;
    logic [3:0] atag;
    logic       rv;
    logic [5:0] rphys;
    logic [4:0] crd;
    logic [5:0] cphys;
    logic [4:0] cnt;
    logic       emp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic av, input int rd, input int np, input int op,
                     input logic dv, input int dt, input logic rr, input logic fl,
                     input logic ardy, input int atag, input logic rv, input int rphys,
                     input int crd, input int cphys, input int cnt, input logic emp);
    vec_t v;
    v.av = av; v.rd = 5'(rd); v.np = 6'(np); v.op = 6'(op);
    v.dv = dv; v.dt = 4'(dt); v.rr = rr; v.fl = fl;
    v.ardy = ardy; v.atag = 4'(atag); v.rv = rv; v.rphys = 6'(rphys);
    v.crd = 5'(crd); v.cphys = 6'(cphys); v.cnt = 5'(cnt); v.emp = emp;
    vq.push_back(v);
  endtask

  task automatic set_idle();
    bus.alloc_valid    = 1'b0;
    bus.alloc_arch_rd  = '0;
    bus.alloc_new_phys = '0;
    bus.alloc_old_phys = '0;
    bus.done_valid     = 1'b0;
    bus.done_tag       = '0;
    bus.release_ready  = 1'b1;
    bus.flush          = 1'b0;
  endtask

  task automatic push_in(input int rd, input int np, input int op);
    bus.alloc_valid    = 1'b1;
    bus.alloc_arch_rd  = 5'(rd);
    bus.alloc_new_phys = 6'(np);
    bus.alloc_old_phys = 6'(op);
  endtask

  // Push/complete/retire n entries back to back; a queue models the expected retire order.
  task automatic run_stream(input int n);
    int         pushed = 0;
    int         retired = 0;
    int         cyc = 0;
    logic [3:0] exp_tag = '0;
    logic [3:0] last_tag = '0;
    bit         have_last = 0;
    logic [5:0] q_old[$];
    logic [5:0] q_new[$];
    while (retired < n && cyc < 400) begin
      @(negedge clk);
      set_idle();
      if (pushed < n) push_in(pushed % 32, pushed, 63 - pushed);
      bus.done_valid = have_last;
      bus.done_tag   = last_tag;
      #1;
      if (bus.release_valid) begin
        if (q_old.size() == 0) begin
          chk("stream_spurious_release", 1, 0);
        end else begin
          chk("stream_release_phys", bus.release_phys, q_old.pop_front());
          chk("stream_commit_phys", bus.commit_phys, q_new.pop_front());
        end
        retired++;
      end
      chk("stream_count_le16", bus.count <= 5'd16, 1);
      have_last = 0;
      if (bus.alloc_valid) begin
        chk("stream_alloc_tag", bus.alloc_tag, exp_tag);
        if (bus.alloc_ready) begin
          q_old.push_back(bus.alloc_old_phys);
          q_new.push_back(bus.alloc_new_phys);
          last_tag  = exp_tag;
          have_last = 1;
          exp_tag   = exp_tag + 4'd1;
          pushed++;
        end
      end
      cyc++;
    end
    chk("stream_retired_total", retired, n);
    @(negedge clk);
    set_idle();
    #1;
    chk("stream_drained_count", bus.count, 0);
    chk("stream_pending_left", q_old.size(), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    set_idle();

    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_alloc_tag", bus.alloc_tag, 0);
    chk("rst_release_valid", bus.release_valid, 0);
    chk("rst_release_phys", bus.release_phys, 0);
    chk("rst_commit_arch", bus.commit_arch_rd, 0);
    chk("rst_commit_phys", bus.commit_phys, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //   av rd np op  dv dt rr fl  ardy atag rv rphys crd cphys cnt emp
    add(1, 3, 33, 3,  0, 0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 1);
    add(0, 0, 0, 0,   1, 0, 1, 0,  1, 1, 0, 0, 0, 0,  1, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 1, 1, 3, 3, 33, 1, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 1, 0, 0, 0, 0,  0, 1);
    add(0, 0, 0, 0,   0, 0, 1, 1,  1, 1, 0, 0, 0, 0,  0, 1);
    add(1, 1, 40, 1,  0, 0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 1);
    add(1, 2, 41, 2,  0, 0, 1, 0,  1, 1, 0, 0, 0, 0,  1, 0);
    add(1, 4, 42, 4,  0, 0, 1, 0,  1, 2, 0, 0, 0, 0,  2, 0);
    add(0, 0, 0, 0,   1, 2, 1, 0,  1, 3, 0, 0, 0, 0,  3, 0);
    add(0, 0, 0, 0,   1, 1, 1, 0,  1, 3, 0, 0, 0, 0,  3, 0);
    add(0, 0, 0, 0,   1, 0, 1, 0,  1, 3, 0, 0, 0, 0,  3, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 3, 1, 1, 1, 40, 3, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 3, 1, 2, 2, 41, 2, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 3, 1, 4, 4, 42, 1, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 3, 0, 0, 0, 0,  0, 1);
    add(1, 5, 50, 20, 0, 0, 1, 0,  1, 3, 0, 0, 0, 0,  0, 1);
    add(1, 6, 51, 21, 1, 3, 1, 0,  1, 4, 0, 0, 0, 0,  1, 0);
    add(1, 7, 52, 22, 0, 0, 0, 0,  1, 5, 1, 20, 5, 50, 2, 0);
    add(1, 8, 53, 23, 0, 0, 0, 0,  1, 6, 1, 20, 5, 50, 3, 0);
    add(1, 9, 54, 24, 0, 0, 0, 0,  1, 7, 1, 20, 5, 50, 4, 0);
    add(0, 0, 0, 0,   0, 0, 0, 0,  1, 8, 1, 20, 5, 50, 5, 0);
    add(0, 0, 0, 0,   0, 0, 0, 0,  1, 8, 1, 20, 5, 50, 5, 0);
    add(0, 0, 0, 0,   0, 0, 0, 0,  1, 8, 1, 20, 5, 50, 5, 0);
    add(1, 10, 55, 25, 1, 4, 1, 1, 1, 8, 0, 0, 0, 0,  5, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 1);
    add(0, 0, 0, 0,   1, 0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 1);
    add(1, 1, 2, 3,   0, 0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 1);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 1, 0, 0, 0, 0,  1, 0);
    add(0, 0, 0, 0,   1, 0, 1, 0,  1, 1, 0, 0, 0, 0,  1, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 1, 1, 3, 1, 2,  1, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0,  1, 1, 0, 0, 0, 0,  0, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      bus.alloc_valid    = vq[i].av;
      bus.alloc_arch_rd  = vq[i].rd;
      bus.alloc_new_phys = vq[i].np;
      bus.alloc_old_phys = vq[i].op;
      bus.done_valid     = vq[i].dv;
      bus.done_tag       = vq[i].dt;
      bus.release_ready  = vq[i].rr;
      bus.flush          = vq[i].fl;
      #1;
      chk($sformatf("v%0d_alloc_ready", i), bus.alloc_ready, vq[i].ardy);
      chk($sformatf("v%0d_alloc_tag", i), bus.alloc_tag, vq[i].atag);
      chk($sformatf("v%0d_release_valid", i), bus.release_valid, vq[i].rv);
      chk($sformatf("v%0d_release_phys", i), bus.release_phys, vq[i].rphys);
      chk($sformatf("v%0d_commit_arch", i), bus.commit_arch_rd, vq[i].crd);
      chk($sformatf("v%0d_commit_phys", i), bus.commit_phys, vq[i].cphys);
      chk($sformatf("v%0d_count", i), bus.count, vq[i].cnt);
      chk($sformatf("v%0d_empty", i), bus.empty, vq[i].emp);
    end

    // Fill to 16 from head=tail=1, then retire while a push is offered.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_idle();
      push_in(i, i + 16, i + 1);
      bus.release_ready = 1'b0;
      #1;
      chk($sformatf("fill%0d_count", i), bus.count, i);
      chk($sformatf("fill%0d_ready", i), bus.alloc_ready, 1);
    end
    @(negedge clk);
    set_idle();
    bus.done_valid = 1'b1;
    bus.done_tag   = 4'd1;
    #1;
    chk("full_count", bus.count, 16);
    chk("full_alloc_ready", bus.alloc_ready, 0);
    chk("full_alloc_tag", bus.alloc_tag, 1);
    @(negedge clk);
    set_idle();
    push_in(31, 63, 62);
    #1;
    chk("full_retire_valid", bus.release_valid, 1);
    chk("full_retire_phys", bus.release_phys, 1);
    chk("full_no_bypass", bus.alloc_ready, 0);
    @(negedge clk);
    set_idle();
    #1;
    chk("after_retire_count", bus.count, 15);
    chk("after_retire_ready", bus.alloc_ready, 1);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    set_idle();
    #1;
    chk("flush_clears_count", bus.count, 0);

    run_stream(40);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    set_idle();
    push_in(9, 9, 9);
    @(posedge clk);
    #2;
    set_idle();
    chk("pre_arst_count", bus.count, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_alloc_tag", bus.alloc_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef RETIRE_STATS_EN
    run_stream(20);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_idle();
      push_in(i, i, i);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle();
      push_in(1, 1, 1);
    end
    @(negedge clk);
    set_idle();
    #1;
    chk("stats_retire_cnt", retire_cnt, 20);
    chk("stats_stall_cnt", stall_cnt, 4);
    bus.flush = 1'b1;
    @(negedge clk);
    set_idle();
    #1;
    chk("stats_retire_after_flush", retire_cnt, 20);
    chk("stats_stall_after_flush", stall_cnt, 4);
    chk("stats_flush_count", bus.count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
